// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the sort_ctrl slice.
//   N_WORDS      - words per frame (the network is fixed at four inputs)
//   word_t       - default 4-bit word type
//   sort_state_t - controller FSM states
package sort_pkg;

    localparam int N_WORDS = 4;

    typedef logic [3:0] word_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

endpackage

// File: rtl/sort4_net.sv
// sort4_net: combinational 4-word sorting network, non-increasing order.
// Ports:
//   in_words  [4*W-1:0] - {w3, w2, w1, w0}
//   out_words [4*W-1:0] - sorted, out_words[4W-1 -: W] is the maximum,
//                         out_words[W-1:0] the minimum
module sort4_net #(
    parameter int W = 4
) (
    input  logic [4*W-1:0] in_words,
    output logic [4*W-1:0] out_words
);

    logic [W-1:0] w [4];
    logic [W-1:0] t;

    // Five compare-exchange stages: (0,1) (2,3) (0,2) (1,3) (1,2).
    // Each stage leaves the larger value at the lower index.
    always_comb begin
        t = '0;
        for (int i = 0; i < 4; i++) begin
            w[i] = in_words[i*W +: W];
        end
        if (w[1] > w[0]) begin t = w[0]; w[0] = w[1]; w[1] = t; end
        if (w[3] > w[2]) begin t = w[2]; w[2] = w[3]; w[3] = t; end
        if (w[2] > w[0]) begin t = w[0]; w[0] = w[2]; w[2] = t; end
        if (w[3] > w[1]) begin t = w[1]; w[1] = w[3]; w[3] = t; end
        if (w[2] > w[1]) begin t = w[1]; w[1] = w[2]; w[2] = t; end
        out_words = '0;
        for (int i = 0; i < 4; i++) begin
            out_words[(3-i)*W +: W] = w[i];
        end
    end

endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: serial front end for the 4-word sorting network.
// Loads four words over a valid/ready input stream, sorts them in one
// cycle, then streams them out largest-first over a valid/ready output.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   in_valid/in_ready/in_data    - input word stream
//   out_valid/out_ready/out_data - sorted output stream
//   out_last                     - marks the 4th (smallest) word of a frame
//   abort                        - synchronous frame discard
//   busy                         - high while sorting or draining
//   frame_cnt                    - completed frames, wraps at 255
//
// Handshake: a word moves on a stream at a rising clk edge where valid and
// ready are both high. Producers must hold data while valid && !ready;
// this block holds out_data/out_last while out_valid && !out_ready.
// in_ready, out_valid, out_last and busy decode only the registered state.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         abort,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    sort_state_t  state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [W-1:0] buf_q    [N_WORDS];
    logic [W-1:0] buf_d    [N_WORDS];
    logic [W-1:0] sorted_q [N_WORDS];
    logic [W-1:0] sorted_d [N_WORDS];
    logic [7:0]   frame_cnt_q, frame_cnt_d;

    logic [4*W-1:0] net_in;
    logic [4*W-1:0] net_out;

    assign net_in = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};

    sort4_net #(.W(W)) u_net (
        .in_words  (net_in),
        .out_words (net_out)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        sorted_d    = sorted_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    buf_d[idx_q] = in_data;
                    if (idx_q == 2'd3) begin
                        state_d = SORT;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            SORT: begin
                for (int i = 0; i < N_WORDS; i++) begin
                    sorted_d[i] = net_out[(N_WORDS-1-i)*W +: W];
                end
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == 2'd3) begin
                        state_d     = LOAD;
                        idx_d       = 2'd0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = 2'd0;
            end
        endcase
        // Abort overrides any transfer in the same cycle. A partially
        // written buffer is left stale; the next frame overwrites it.
        if (abort) begin
            state_d     = LOAD;
            idx_d       = 2'd0;
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= 2'd0;
            frame_cnt_q <= 8'd0;
            for (int i = 0; i < N_WORDS; i++) begin
                buf_q[i]    <= '0;
                sorted_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            buf_q       <= buf_d;
            sorted_q    <= sorted_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (idx_q == 2'd3);
    assign busy      = (state_q != LOAD);
    assign out_data  = sorted_q[idx_q];
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: directed and randomized bench for sort_ctrl.
// Reference: each accepted frame is sorted descending with a queue rsort
// and its words are appended to exp_q; drained words are popped from exp_q.
module tb_sort_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         abort;
    logic         busy;
    logic [7:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    logic [W-1:0] exp_q   [$];
    logic [W-1:0] frame_q [$];

    sort_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .abort     (abort),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A complete input frame becomes four expected words, largest first.
    task automatic model_frame();
        logic [W-1:0] s [$];
        s = frame_q;
        s.rsort();
        foreach (s[i]) exp_q.push_back(s[i]);
        frame_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic push(input logic [W-1:0] w, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 8'(n < 20), 8'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_q.push_back(w);
        if (frame_q.size() == 4) model_frame();
    endtask

    task automatic push4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        push(a, 0);
        push(b, 0);
        push(c, 0);
        push(d, 0);
    endtask

    // Pops n words; word stall_at is held with out_ready low for stall_len
    // cycles, or every word gets a random stall when rnd is set.
    task automatic pop_words(input int n_words, input int stall_at,
                             input int stall_len, input bit rnd);
        int n;
        int s;
        logic [W-1:0] held;
        logic [W-1:0] exp;
        for (int k = 0; k < n_words; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("out_valid_wait", 8'(n < 20), 8'd1);
            s = rnd ? int'($urandom_range(0, 2)) : ((k == stall_at) ? stall_len : 0);
            held = out_data;
            repeat (s) begin
                chk("hold_valid", 8'(out_valid), 8'd1);
                chk("hold_data", 8'(out_data), 8'(held));
                chk("hold_in_ready", 8'(in_ready), 8'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("out_data", 8'(out_data), 8'(exp));
            chk("out_last", 8'(out_last), 8'(k == 3));
            chk("busy_drain", 8'(busy), 8'd1);
            chk("in_ready_drain", 8'(in_ready), 8'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic pop_frame(input int stall_at, input int stall_len, input bit rnd);
        pop_words(4, stall_at, stall_len, rnd);
        exp_frames++;
        chk("frame_cnt", frame_cnt, 8'(exp_frames));
        chk("back_to_load", 8'(in_ready), 8'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n_rand;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        abort     = 1'b0;
        #12;
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", 8'(out_data), 8'd0);
        chk("rst_out_last", 8'(out_last), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame with latency check: SORT after the 4th edge,
        // out_valid one edge later.
        push4(4'h3, 4'h9, 4'h0, 4'h9);
        chk("sort_in_ready", 8'(in_ready), 8'd0);
        chk("sort_out_valid", 8'(out_valid), 8'd0);
        chk("sort_busy", 8'(busy), 8'd1);
        @(posedge clk);
        #1;
        chk("first_out_valid", 8'(out_valid), 8'd1);
        chk("first_out_data", 8'(out_data), 8'h9);
        pop_frame(-1, 0, 1'b0);

        // Asynchronous reset mid-load, observed before the next edge.
        push(4'h4, 0);
        push(4'h2, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", 8'(in_ready), 8'd1);
        chk("async_out_valid", 8'(out_valid), 8'd0);
        chk("async_out_data", 8'(out_data), 8'd0);
        chk("async_frame_cnt", frame_cnt, 8'd0);
        frame_q.delete();
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b0;
        push(4'h6, 1); push(4'hC, 0); push(4'h1, 2); push(4'h8, 0);
        pop_frame(-1, 0, 1'b0);

        // Input gaps and a 3-cycle stall on the second output word.
        push(4'hA, 0); push(4'h2, 1); push(4'hA, 0); push(4'h5, 1);
        pop_frame(1, 3, 1'b0);

        // Abort during DRAIN after two outputs.
        push4(4'h4, 4'h8, 4'h2, 4'h6);
        pop_words(2, -1, 0, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        chk("abort_out_valid", 8'(out_valid), 8'd0);
        chk("abort_in_ready", 8'(in_ready), 8'd1);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_frame_cnt", frame_cnt, 8'(exp_frames));
        push4(4'hF, 4'h1, 4'h7, 4'h1);
        pop_frame(-1, 0, 1'b0);

        // Abort coinciding with the 4th input word.
        push(4'h3, 0); push(4'h5, 0); push(4'h9, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'hE;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        frame_q.delete();
        chk("abort4_in_ready", 8'(in_ready), 8'd1);
        chk("abort4_busy", 8'(busy), 8'd0);
        @(posedge clk);
        #1;
        chk("abort4_no_drain", 8'(out_valid), 8'd0);
        push4(4'h2, 4'h7, 4'h7, 4'hB);
        pop_frame(-1, 0, 1'b0);

        // Abort coinciding with the out_last transfer.
        push4(4'h1, 4'h2, 4'h3, 4'h4);
        pop_words(3, -1, 0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        abort     = 1'b0;
        exp_q.delete();
        chk("abort_last_cnt", frame_cnt, 8'(exp_frames));
        chk("abort_last_valid", 8'(out_valid), 8'd0);

        // Ties and extremes.
        push4(4'h0, 4'h0, 4'h0, 4'h0);
        pop_frame(-1, 0, 1'b0);
        push4(4'hF, 4'hF, 4'hF, 4'hF);
        pop_frame(-1, 0, 1'b0);
        push4(4'h0, 4'hF, 4'h0, 4'hF);
        pop_frame(-1, 0, 1'b0);

        // Random frames: at least 256, ending on a multiple of 256 so the
        // counter has wrapped back to zero.
        n_rand = 256 + ((256 - (exp_frames % 256)) % 256);
        for (int f = 0; f < n_rand; f++) begin
            for (int j = 0; j < 4; j++) begin
                push(W'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            end
            pop_frame(-1, 0, 1'b1);
        end
        chk("frame_cnt_wrap", frame_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
